awmc_actuator_driver: RTL and testbench

Downstream stage of the washing machine FSM. It consumes the FSM's 3-bit `stage` code and `done` flag, and drives the physical actuators: inlet valve, drain pump and drum motor (enable/direction/speed), plus the end-of-cycle buzzer. It enforces actuator dead-time between stages, generates the wash/rinse agitation pattern and applies a door interlock.

---
 rtl/awmc_pkg.sv | 18 +
 rtl/awmc_beep_gen.sv | 53 +++++
 rtl/awmc_actuator_driver.sv | 162 ++++++++++++++++
 tb/tb_awmc_actuator_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/awmc_pkg.sv
// Shared stage codes and agitation phase type for the washing-machine actuator path.
package awmc_pkg;

  localparam logic [2:0] STG_FILL  = 3'd0;
  localparam logic [2:0] STG_WASH  = 3'd1;
  localparam logic [2:0] STG_DRAIN = 3'd2;
  localparam logic [2:0] STG_RINSE = 3'd3;
  localparam logic [2:0] STG_SPIN  = 3'd4;
  localparam logic [2:0] STG_IDLE  = 3'd7;

  typedef enum logic [1:0] {FWD, GAP1, REV, GAP2} agit_phase_t;

  // Codes 0..4 are the stages that drive actuators; 5, 6 and 7 never do.
  function automatic logic is_active_stage(input logic [2:0] s);
    return s <= STG_SPIN;
  endfunction

endpackage

// File: rtl/awmc_beep_gen.sv
// Completion beeper: each trig pulse (re)starts a train of BEEP_N beeps, BEEP_ON high / BEEP_ON low.
module awmc_beep_gen #(
  parameter int BEEP_ON = 4,
  parameter int BEEP_N  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic buzzer
);

  localparam int CNT_W = $clog2(BEEP_ON + 1);
  localparam int NUM_W = $clog2(BEEP_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEEP_ON - 1);
  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(BEEP_N - 1);

  logic             run;
  logic             hi;
  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] num;

  always_ff @(posedge clk) begin
    if (!reset) begin
      run    <= 1'b0;
      hi     <= 1'b0;
      cnt    <= '0;
      num    <= '0;
      buzzer <= 1'b0;
    end else if (trig) begin
      // Restart from beep 1; the first high cycle appears on the following edge.
      run    <= 1'b1;
      hi     <= 1'b1;
      cnt    <= '0;
      num    <= '0;
      buzzer <= 1'b0;
    end else if (run) begin
      buzzer <= hi;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        hi  <= !hi;
        if (!hi) begin
          if (num == NUM_LAST) run <= 1'b0;
          else                 num <= num + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      buzzer <= 1'b0;
    end
  end

endmodule

// File: rtl/awmc_actuator_driver.sv
// Actuator driver: stage decode with dead-time, wash/rinse agitation, door interlock and completion buzzer.
module awmc_actuator_driver
  import awmc_pkg::*;
#(
  parameter int DEAD_CYC = 4,
  parameter int AGIT_ON  = 8,
  parameter int AGIT_GAP = 2,
  parameter int BEEP_ON  = 4,
  parameter int BEEP_N   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] stage,
  input  logic       done,
  input  logic       door_closed,
  output logic       inlet_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       buzzer,
  output logic       fault
);

  localparam int DEAD_W   = $clog2(DEAD_CYC + 1);
  localparam int AGIT_MAX = (AGIT_ON > AGIT_GAP) ? AGIT_ON : AGIT_GAP;
  localparam int AGIT_W   = $clog2(AGIT_MAX + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC);
  localparam logic [AGIT_W-1:0] ON_LAST   = AGIT_W'(AGIT_ON - 1);
  localparam logic [AGIT_W-1:0] GAP_LAST  = AGIT_W'(AGIT_GAP - 1);

  logic [2:0]        stage_q;
  logic              done_q;
  logic [DEAD_W-1:0] dead_cnt;
  agit_phase_t       phase;
  logic [AGIT_W-1:0] agit_cnt;

  logic              stage_chg;
  logic              stage_entry;
  logic              fault_set;
  logic              fault_clr;
  logic              act_ok;
  logic              agit_run;
  logic              phase_last;
  agit_phase_t       phase_n;
  logic [AGIT_W-1:0] agit_cnt_n;
  logic [DEAD_W-1:0] dead_cnt_n;
  logic              fault_n;
  logic              agit_en;
  logic              agit_dir;
  logic              inlet_n;
  logic              pump_n;
  logic              en_n;
  logic              dir_n;
  logic              fast_n;

  always_comb begin
    stage_chg   = (stage != stage_q);
    stage_entry = stage_chg && is_active_stage(stage);
    fault_set   = !door_closed && is_active_stage(stage_q);
    fault_clr   = (stage_q == STG_IDLE) && door_closed;
    // Actuators drive only in a settled stage, past dead time, with no interlock fault.
    act_ok      = !stage_chg && (dead_cnt == '0) && !fault && !fault_set;
    agit_run    = act_ok && ((stage_q == STG_WASH) || (stage_q == STG_RINSE));
  end

  always_comb begin
    phase_n    = phase;
    agit_cnt_n = agit_cnt;
    agit_en    = 1'b0;
    agit_dir   = motor_dir;
    phase_last = (phase == FWD || phase == REV) ? (agit_cnt == ON_LAST)
                                                : (agit_cnt == GAP_LAST);
    // Direction flips on the last gap cycle so it never changes while the motor is moving.
    unique case (phase)
      FWD:  begin agit_en = 1'b1; agit_dir = 1'b0; end
      GAP1: agit_dir = phase_last ? 1'b1 : motor_dir;
      REV:  begin agit_en = 1'b1; agit_dir = 1'b1; end
      GAP2: agit_dir = phase_last ? 1'b0 : motor_dir;
    endcase
    if (stage_entry) begin
      phase_n    = FWD;
      agit_cnt_n = '0;
    end else if (agit_run) begin
      if (phase_last) begin
        agit_cnt_n = '0;
        unique case (phase)
          FWD:  phase_n = GAP1;
          GAP1: phase_n = REV;
          REV:  phase_n = GAP2;
          GAP2: phase_n = FWD;
        endcase
      end else begin
        agit_cnt_n = agit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    inlet_n = 1'b0;
    pump_n  = 1'b0;
    en_n    = 1'b0;
    dir_n   = 1'b0;
    fast_n  = 1'b0;
    if (act_ok) begin
      unique case (stage_q)
        STG_FILL:  inlet_n = 1'b1;
        STG_WASH:  begin en_n = agit_en; dir_n = agit_dir; end
        STG_DRAIN: pump_n = 1'b1;
        STG_RINSE: begin inlet_n = 1'b1; en_n = agit_en; dir_n = agit_dir; end
        STG_SPIN:  begin pump_n = 1'b1; en_n = 1'b1; fast_n = 1'b1; end
        default:   ;
      endcase
    end
    if (stage_entry)            dead_cnt_n = DEAD_LOAD;
    else if (dead_cnt != '0)    dead_cnt_n = dead_cnt - 1'b1;
    else                        dead_cnt_n = dead_cnt;
    if (fault_set)              fault_n = 1'b1;
    else if (fault_clr)         fault_n = 1'b0;
    else                        fault_n = fault;
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q     <= STG_IDLE;
      done_q      <= 1'b0;
      dead_cnt    <= '0;
      phase       <= FWD;
      agit_cnt    <= '0;
      fault       <= 1'b0;
      inlet_valve <= 1'b0;
      drain_pump  <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      motor_fast  <= 1'b0;
    end else begin
      stage_q     <= stage;
      done_q      <= done;
      dead_cnt    <= dead_cnt_n;
      phase       <= phase_n;
      agit_cnt    <= agit_cnt_n;
      fault       <= fault_n;
      inlet_valve <= inlet_n;
      drain_pump  <= pump_n;
      motor_en    <= en_n;
      motor_dir   <= dir_n;
      motor_fast  <= fast_n;
    end
  end

  awmc_beep_gen #(
    .BEEP_ON (BEEP_ON),
    .BEEP_N  (BEEP_N)
  ) u_beep (
    .clk    (clk),
    .reset  (reset),
    .trig   (done && !done_q),
    .buzzer (buzzer)
  );

endmodule

// File: tb/tb_awmc_actuator_driver.sv
// Directed bench for awmc_actuator_driver with hand-derived expectations (DEAD_CYC=4, AGIT 8/2, beep 4x3).
module tb_awmc_actuator_driver;

  logic       clk;
  logic       reset;
  logic [2:0] stage;
  logic       done;
  logic       door_closed;
  logic       inlet_valve;
  logic       drain_pump;
  logic       motor_en;
  logic       motor_dir;
  logic       motor_fast;
  logic       buzzer;
  logic       fault;

  int n_pass  = 0;
  int n_total = 0;

  awmc_actuator_driver dut (
    .clk         (clk),
    .reset       (reset),
    .stage       (stage),
    .done        (done),
    .door_closed (door_closed),
    .inlet_valve (inlet_valve),
    .drain_pump  (drain_pump),
    .motor_en    (motor_en),
    .motor_dir   (motor_dir),
    .motor_fast  (motor_fast),
    .buzzer      (buzzer),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] act();
    return {inlet_valve, drain_pump, motor_en, motor_dir, motor_fast};
  endfunction

  // Expected {inlet,pump,en,dir,fast} p cycles after the first driven agitation edge.
  function automatic logic [4:0] agit_exp(input int p);
    int   m;
    logic en;
    logic dir;
    if (p < 0) return 5'b0;
    m   = p % 20;
    en  = (m < 8) || (m >= 10 && m < 18);
    dir = (m == 9) || (m >= 10 && m <= 18);
    return {2'b00, en, dir, 1'b0};
  endfunction

  function automatic logic beep_exp(input int j);
    return (j >= 1) && (j <= 24) && (((j - 1) / 4) % 2 == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic prev_en;
    logic prev_dir;
    logic [4:0] a;

    reset = 1'b0; stage = 3'd0; done = 1'b1; door_closed = 1'b1;
    repeat (3) tick();
    chk("reset_act", act(), 5'b0);
    chk("reset_buzzer", buzzer, 1'b0);
    chk("reset_fault", fault, 1'b0);

    // Release: FILL captured at edge 1, inlet opens at edge 6.
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("fill_dead", act(), 5'b0);
      if (e == 2) chk("reset_rise_beep", buzzer, 1'b1);
    end
    tick();
    chk("fill_on", act(), 5'b10000);

    // IDLE then WASH agitation pattern
    stage = 3'd7; done = 1'b0;
    tick();
    chk("idle_off", act(), 5'b0);
    stage = 3'd1;
    tick();
    chk("wash_entry", act(), 5'b0);
    prev_en = 1'b0; prev_dir = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      a = act();
      chk("wash_agit", a, agit_exp(e - 5));
      if (a[1] != prev_dir) chk("dir_toggle_while_on", {prev_en, a[2]}, 2'b00);
      prev_en = a[2]; prev_dir = a[1];
    end

    // WASH -> SPIN mid reverse stroke
    stage = 3'd4;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk("spin_dead", act(), 5'b0);
    end
    tick();
    chk("spin_on", act(), 5'b01101);
    stage = 3'd5;
    tick();
    chk("invalid_off", act(), 5'b0);

    // Door interlock in WASH
    stage = 3'd1;
    repeat (9) tick();
    chk("wash_fwd", act(), 5'b00100);
    door_closed = 1'b0;
    tick();
    chk("fault_set", fault, 1'b1);
    chk("fault_act", act(), 5'b0);
    door_closed = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("fault_hold_act", act(), 5'b0);
      chk("fault_latched", fault, 1'b1);
    end
    stage = 3'd7;
    tick();
    chk("fault_until_idle", fault, 1'b1);
    tick();
    chk("fault_clear", fault, 1'b0);
    door_closed = 1'b0;
    tick();
    chk("idle_door_open", fault, 1'b0);
    door_closed = 1'b1;

    // Single done pulse -> 24-cycle beep train
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      tick();
      chk("beep_train", buzzer, beep_exp(j));
    end

    // Retrigger 10 cycles into a train
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      chk("beep_pre_retrig", buzzer, beep_exp(j));
    end
    done = 1'b1;
    tick();
    chk("beep_retrig_edge", buzzer, 1'b0);
    for (int j = 1; j <= 25; j++) begin
      tick();
      if (j == 1) done = 1'b1;
      chk("beep_retrain", buzzer, beep_exp(j));
    end
    // done held high since the retrigger: no further beeps
    repeat (5) tick();
    chk("beep_level_held", buzzer, 1'b0);
    done = 1'b0;

    // Pause and resume WASH
    stage = 3'd1;
    repeat (8) tick();
    chk("pre_pause_fwd", act(), 5'b00100);
    stage = 3'd7;
    tick();
    chk("pause_off", act(), 5'b0);
    repeat (5) tick();
    chk("pause_hold", act(), 5'b0);
    stage = 3'd1;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk("resume_dead", act(), 5'b0);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("resume_fwd", act(), 5'b00100);
    end
    tick();
    chk("resume_gap", act(), 5'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
